// File: rtl/axi_stream_pkt_arbiter.sv
// Round-robin, packet-atomic N:1 AXI Stream arbiter with a registered output stage.
// Once a port wins, it keeps the grant until the beat carrying tlast, so packets never interleave.
package axi_stream_pkt_arbiter_pkg;

  typedef struct packed {
    logic [7:0] data;
    logic [0:0] strb;
    logic [0:0] keep;
    logic       last;
    logic [0:0] id;
    logic [0:0] dest;
    logic [0:0] user;
  } axi_stream_t_chan_t;

  typedef struct packed {
    logic               tvalid;
    axi_stream_t_chan_t t;
  } axi_stream_req_t;

  typedef struct packed {
    logic tready;
  } axi_stream_rsp_t;

endpackage

module axi_stream_pkt_arbiter #(
  parameter int  NumInp    = 4,
  parameter int  DataWidth = 8,
  parameter int  IdWidth   = 0,
  parameter int  DestWidth = 0,
  parameter int  UserWidth = 0,
  parameter type axi_stream_req_t = axi_stream_pkt_arbiter_pkg::axi_stream_req_t,
  parameter type axi_stream_rsp_t = axi_stream_pkt_arbiter_pkg::axi_stream_rsp_t,
  localparam int IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_stream_req_t     in_req_i [NumInp],
  output axi_stream_rsp_t     in_rsp_o [NumInp],
  output axi_stream_req_t     out_req_o,
  input  axi_stream_rsp_t     out_rsp_i,
  output logic [IdxWidth-1:0] grant_idx_o,
  output logic                busy_o
);

  typedef enum logic {
    Arb,
    Locked
  } state_e;

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0] grant_idx_q, grant_idx_d;
  axi_stream_req_t     out_q;

  logic [IdxWidth-1:0] scan_idx;
  logic                scan_found;
  int                  scan_cand;
  logic [IdxWidth-1:0] sel;
  logic                sel_ready;
  logic                accept;
  logic                can_load;

  function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
    if (int'(idx) >= NumInp - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  assign can_load = !out_q.tvalid || out_rsp_i.tready;

  // Walk backwards from the farthest offset so the closest valid port to rr_ptr wins last.
  always_comb begin
    scan_idx   = rr_ptr_q;
    scan_found = 1'b0;
    scan_cand  = 0;
    for (int i = NumInp - 1; i >= 0; i--) begin
      scan_cand = int'(rr_ptr_q) + i;
      if (scan_cand >= NumInp) begin
        scan_cand = scan_cand - NumInp;
      end
      if (in_req_i[scan_cand].tvalid) begin
        scan_idx   = scan_cand[IdxWidth-1:0];
        scan_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_idx_d  = lock_idx_q;
    grant_idx_d = grant_idx_q;
    sel         = scan_idx;
    sel_ready   = 1'b0;
    for (int i = 0; i < NumInp; i++) begin
      in_rsp_o[i] = '0;
    end

    unique case (state_q)
      Arb: begin
        sel       = scan_idx;
        sel_ready = scan_found && can_load;
      end
      Locked: begin
        sel       = lock_idx_q;
        sel_ready = can_load;
      end
      default: ;
    endcase

    in_rsp_o[sel].tready = sel_ready;
    accept = in_req_i[sel].tvalid && sel_ready;

    // Leaving on tlast hands priority to the port after the finishing one.
    if (accept) begin
      grant_idx_d = sel;
      if (in_req_i[sel].t.last) begin
        state_d  = Arb;
        rr_ptr_d = next_idx(sel);
      end else begin
        state_d    = Locked;
        lock_idx_d = sel;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Arb;
      rr_ptr_q    <= '0;
      lock_idx_q  <= '0;
      grant_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_idx_q  <= lock_idx_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else if (accept) begin
      out_q <= in_req_i[sel];
    end else if (out_rsp_i.tready) begin
      out_q.tvalid <= 1'b0;
    end
  end

  assign out_req_o   = out_q;
  assign grant_idx_o = grant_idx_q;
  assign busy_o      = (state_q == Locked) || out_q.tvalid;

  logic [NumInp-1:0] ready_vec;

  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      ready_vec[i] = in_rsp_o[i].tready;
    end
  end

  // Struct field widths must agree with the width parameters (zero-width fields occupy one bit).
  assert property (@(posedge clk_i) NumInp >= 1);
  assert property (@(posedge clk_i) $bits(out_q.t.data) == DataWidth);
  assert property (@(posedge clk_i) $bits(out_q.t.id) == ((IdWidth > 0) ? IdWidth : 1));
  assert property (@(posedge clk_i) $bits(out_q.t.dest) == ((DestWidth > 0) ? DestWidth : 1));
  assert property (@(posedge clk_i) $bits(out_q.t.user) == ((UserWidth > 0) ? UserWidth : 1));
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ready_vec));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   (out_q.tvalid && !out_rsp_i.tready) |=> $stable(out_q));

endmodule

// File: tb/tb_axi_stream_pkt_arbiter.sv
// Scoreboard bench for axi_stream_pkt_arbiter: hand-ordered expected beats are queued with the
// stimulus and popped whenever the output handshakes.
module tb_axi_stream_pkt_arbiter;
  import axi_stream_pkt_arbiter_pkg::*;

  localparam int NumInp   = 4;
  localparam int IdxWidth = 2;

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic                clk_i  = 1'b0;
  logic                rst_ni = 1'b0;
  axi_stream_req_t     in_req [NumInp];
  axi_stream_rsp_t     in_rsp [NumInp];
  axi_stream_req_t     out_req;
  axi_stream_rsp_t     out_rsp;
  logic [IdxWidth-1:0] grant_idx;
  logic                busy;

  beat_t src_q [$];
  beat_t exp_q [$];
  int    acc_q [$];
  logic  hold [NumInp];

  int cyc          = 0;
  int n_checks     = 0;
  int n_fail       = 0;
  int watch_port   = -1;
  int stall_data   = -1;
  bit latency_check = 1'b0;
  int out_count    = 0;
  int first_out    = 0;
  int last_out     = 0;

  axi_stream_pkt_arbiter #(
    .NumInp   (NumInp),
    .DataWidth(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_req_i   (in_req),
    .in_rsp_o   (in_rsp),
    .out_req_o  (out_req),
    .out_rsp_i  (out_rsp),
    .grant_idx_o(grant_idx),
    .busy_o     (busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int headIdx(input int p);
    foreach (src_q[i]) begin
      if (src_q[i].port == p) return i;
    end
    return -1;
  endfunction

  task automatic addSrc(input int p, input logic [7:0] d, input logic l);
    beat_t b;
    b.port = p;
    b.data = d;
    b.last = l;
    src_q.push_back(b);
  endtask

  task automatic addExp(input int p, input logic [7:0] d, input logic l);
    beat_t b;
    b.port = p;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic addBoth(input int p, input logic [7:0] d, input logic l);
    addSrc(p, d, l);
    addExp(p, d, l);
  endtask

  task automatic driveInputs();
    int idx;
    for (int p = 0; p < NumInp; p++) begin
      in_req[p] = '0;
      idx = headIdx(p);
      if (idx >= 0 && !hold[p]) begin
        in_req[p].tvalid = 1'b1;
        in_req[p].t.data = src_q[idx].data;
        in_req[p].t.last = src_q[idx].last;
        in_req[p].t.strb = 1'b1;
        in_req[p].t.keep = 1'b1;
        in_req[p].t.user = src_q[idx].data[0];
      end
    end
  endtask

  // Sample on the falling edge, then retire accepted beats and redrive just after the rising edge.
  task automatic applyStimulus(input int n);
    logic  hs [NumInp];
    beat_t e;
    int    a;
    int    idx;
    repeat (n) begin
      @(negedge clk_i);
      cyc++;
      for (int p = 0; p < NumInp; p++) begin
        hs[p] = in_req[p].tvalid && in_rsp[p].tready;
      end
      if (watch_port >= 0) begin
        checkOutput("blocked tready", 32'(in_rsp[watch_port].tready), 32'd0);
      end
      if (stall_data >= 0) begin
        checkOutput("stall hold", {23'd0, out_req.tvalid, out_req.t.data}, 32'h100 | stall_data);
      end
      if (out_req.tvalid && out_rsp.tready) begin
        out_count++;
        if (out_count == 1) first_out = cyc;
        last_out = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("extra out beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out beat", {20'd0, grant_idx, out_req.t.last, out_req.t.user, out_req.t.data},
                      {20'd0, e.port[1:0], e.last, e.data[0], e.data});
        end
        if (acc_q.size() > 0) begin
          a = acc_q.pop_front();
          if (latency_check) checkOutput("latency", cyc - a, 32'd1);
        end
      end
      for (int p = 0; p < NumInp; p++) begin
        if (hs[p]) acc_q.push_back(cyc);
      end
      @(posedge clk_i);
      #1;
      for (int p = 0; p < NumInp; p++) begin
        if (hs[p]) begin
          idx = headIdx(p);
          if (idx >= 0) src_q.delete(idx);
        end
      end
      driveInputs();
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int p = 0; p < NumInp; p++) hold[p] = 1'b0;
    out_rsp.tready = 1'b1;
    driveInputs();
    #2;
    checkOutput("reset tvalid", 32'(out_req.tvalid), 32'd0);
    checkOutput("reset payload", 32'(out_req.t), 32'd0);
    checkOutput("reset grant", 32'(grant_idx), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] single 3-beat packet on port 2");
    latency_check = 1'b1;
    addBoth(2, 8'h11, 1'b0);
    addBoth(2, 8'h22, 1'b0);
    addBoth(2, 8'h33, 1'b1);
    driveInputs();
    waitDrain(20);
    checkOutput("t1 grant", 32'(grant_idx), 32'd2);
    checkOutput("t1 idle busy", 32'(busy), 32'd0);

    $display("[TB] ports 0 and 1 alternate 2-beat packets");
    out_count = 0;
    addSrc(0, 8'h40, 1'b0); addSrc(0, 8'h41, 1'b1); addSrc(0, 8'h42, 1'b0); addSrc(0, 8'h43, 1'b1);
    addSrc(1, 8'h50, 1'b0); addSrc(1, 8'h51, 1'b1); addSrc(1, 8'h52, 1'b0); addSrc(1, 8'h53, 1'b1);
    addExp(0, 8'h40, 1'b0); addExp(0, 8'h41, 1'b1); addExp(1, 8'h50, 1'b0); addExp(1, 8'h51, 1'b1);
    addExp(0, 8'h42, 1'b0); addExp(0, 8'h43, 1'b1); addExp(1, 8'h52, 1'b0); addExp(1, 8'h53, 1'b1);
    driveInputs();
    waitDrain(40);
    checkOutput("t2 beats", out_count, 32'd8);
    checkOutput("t2 no bubble", last_out - first_out + 1, 32'd8);

    $display("[TB] port 0 pauses mid-packet while port 3 waits");
    for (int k = 0; k < 4; k++) addBoth(0, 8'h60 + 8'(k), k == 3);
    driveInputs();
    applyStimulus(2);
    hold[0] = 1'b1;
    addBoth(3, 8'h70, 1'b1);
    driveInputs();
    watch_port = 3;
    applyStimulus(5);
    watch_port = -1;
    checkOutput("t3 locked busy", 32'(busy), 32'd1);
    checkOutput("t3 locked grant", 32'(grant_idx), 32'd0);
    hold[0] = 1'b0;
    driveInputs();
    waitDrain(30);
    checkOutput("t3 final grant", 32'(grant_idx), 32'd3);

    $display("[TB] downstream stall while port 1 streams");
    latency_check = 1'b0;
    for (int k = 0; k < 4; k++) addBoth(1, 8'h80 + 8'(k), k == 3);
    driveInputs();
    applyStimulus(1);
    out_rsp.tready = 1'b0;
    stall_data = 'h80;
    watch_port = 1;
    applyStimulus(4);
    stall_data = -1;
    watch_port = -1;
    out_rsp.tready = 1'b1;
    waitDrain(30);

    $display("[TB] round-robin wrap between ports 3 and 0");
    latency_check = 1'b1;
    addBoth(2, 8'h90, 1'b1);
    driveInputs();
    waitDrain(20);
    addSrc(3, 8'hA0, 1'b1); addSrc(3, 8'hA1, 1'b1);
    addSrc(0, 8'hB0, 1'b1); addSrc(0, 8'hB1, 1'b1);
    addExp(3, 8'hA0, 1'b1); addExp(0, 8'hB0, 1'b1); addExp(3, 8'hA1, 1'b1); addExp(0, 8'hB1, 1'b1);
    driveInputs();
    waitDrain(30);

    $display("[TB] reset in the middle of a port 2 packet");
    latency_check = 1'b0;
    for (int k = 0; k < 4; k++) addBoth(2, 8'hC0 + 8'(k), k == 3);
    driveInputs();
    applyStimulus(2);
    rst_ni = 1'b0;
    #1;
    checkOutput("mid reset tvalid", 32'(out_req.tvalid), 32'd0);
    checkOutput("mid reset payload", 32'(out_req.t), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset grant", 32'(grant_idx), 32'd0);
    exp_q.delete();
    acc_q.delete();
    src_q.delete();
    driveInputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    addSrc(2, 8'hE0, 1'b1);
    addSrc(0, 8'hD0, 1'b1);
    addExp(0, 8'hD0, 1'b1);
    addExp(2, 8'hE0, 1'b1);
    @(posedge clk_i);
    #1;
    driveInputs();
    waitDrain(20);
    checkOutput("sources drained", src_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
